// File: rtl/sc_mem_access_arbiter.sv
// Memory access sequencer for the ARC microprogrammed CPU: arbitrates CPU vs. program loader,
// inserts wait states, waits for memory ready and raises a sticky error on timeout.
module sc_mem_access_arbiter #(
  parameter int DATAWIDTH_ADDR    = 32,
  parameter int DATAWIDTH_DATA    = 32,
  parameter int WAIT_STATES       = 2,
  parameter int TIMEOUT_CYCLES    = 15,
  parameter int DATAWIDTH_TIMEOUT = 4
) (
  input  logic                      SC_MemArb_CLOCK_50,
  input  logic                      SC_MemArb_RESET_InHigh,
  input  logic                      SC_MemArb_Read_InHigh,
  input  logic                      SC_MemArb_Write_InHigh,
  input  logic [DATAWIDTH_ADDR-1:0] SC_MemArb_Addr_InBUS,
  input  logic [DATAWIDTH_DATA-1:0] SC_MemArb_Data_InBUS,
  output logic [DATAWIDTH_DATA-1:0] SC_MemArb_Data_OutBUS,
  output logic                      SC_MemArb_Stall_Out,
  output logic                      SC_MemArb_Done_Out,
  input  logic                      SC_MemArb_LdrReq_InHigh,
  input  logic                      SC_MemArb_LdrWr_InHigh,
  input  logic [DATAWIDTH_ADDR-1:0] SC_MemArb_LdrAddr_InBUS,
  input  logic [DATAWIDTH_DATA-1:0] SC_MemArb_LdrData_InBUS,
  output logic [DATAWIDTH_DATA-1:0] SC_MemArb_LdrData_OutBUS,
  output logic                      SC_MemArb_LdrGrant_Out,
  output logic                      SC_MemArb_LdrAck_Out,
  output logic [DATAWIDTH_ADDR-1:0] SC_MemArb_MemAddr_OutBUS,
  output logic [DATAWIDTH_DATA-1:0] SC_MemArb_MemData_OutBUS,
  output logic                      SC_MemArb_MemRD_Out,
  output logic                      SC_MemArb_MemWR_Out,
  input  logic                      SC_MemArb_MemReady_InHigh,
  input  logic [DATAWIDTH_DATA-1:0] SC_MemArb_MemData_InBUS,
  output logic                      SC_MemArb_Error_Out
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [DATAWIDTH_TIMEOUT-1:0] WAIT_CNT = DATAWIDTH_TIMEOUT'(WAIT_STATES);
  localparam logic [DATAWIDTH_TIMEOUT-1:0] LAST_CNT = DATAWIDTH_TIMEOUT'(TIMEOUT_CYCLES - 1);
  localparam logic [DATAWIDTH_TIMEOUT-1:0] CNT_ONE  = DATAWIDTH_TIMEOUT'(1);

  state_t                      r_state;
  state_t                      w_nextState;
  logic [DATAWIDTH_TIMEOUT-1:0] r_cnt;
  logic                        r_ownerLdr;
  logic                        r_lastLdr;
  logic                        r_dirWr;
  logic [DATAWIDTH_ADDR-1:0]   r_memAddr;
  logic [DATAWIDTH_DATA-1:0]   r_memData;
  logic [DATAWIDTH_DATA-1:0]   r_cpuData;
  logic [DATAWIDTH_DATA-1:0]   r_ldrData;
  logic                        r_error;

  logic w_cpuReq;
  logic w_grantCpu;
  logic w_grantLdr;
  logic w_readyHit;
  logic w_timeout;

  assign w_cpuReq   = SC_MemArb_Read_InHigh | SC_MemArb_Write_InHigh;
  assign w_readyHit = (r_state == S_ACCESS) && (r_cnt >= WAIT_CNT) && SC_MemArb_MemReady_InHigh;
  assign w_timeout  = (r_state == S_ACCESS) && !w_readyHit && (r_cnt == LAST_CNT);

  // Round robin: when both sides ask, the side that did not own the last access wins.
  always_comb begin
    w_nextState = r_state;
    w_grantCpu  = 1'b0;
    w_grantLdr  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cpuReq && (!SC_MemArb_LdrReq_InHigh || r_lastLdr)) begin
          w_grantCpu = 1'b1;
        end else if (SC_MemArb_LdrReq_InHigh) begin
          w_grantLdr = 1'b1;
        end
        if (w_grantCpu || w_grantLdr) begin
          w_nextState = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (w_readyHit || w_timeout) begin
          w_nextState = S_DONE;
        end
      end
      S_DONE:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge SC_MemArb_CLOCK_50) begin
    if (SC_MemArb_RESET_InHigh) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_ownerLdr <= 1'b0;
      r_lastLdr  <= 1'b1;
      r_dirWr    <= 1'b0;
      r_memAddr  <= '0;
      r_memData  <= '0;
      r_cpuData  <= '0;
      r_ldrData  <= '0;
      r_error    <= 1'b0;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          // A CPU read and write raised together is treated as a read.
          if (w_grantCpu) begin
            r_ownerLdr <= 1'b0;
            r_dirWr    <= SC_MemArb_Write_InHigh & ~SC_MemArb_Read_InHigh;
            r_memAddr  <= SC_MemArb_Addr_InBUS;
            r_memData  <= SC_MemArb_Data_InBUS;
          end else if (w_grantLdr) begin
            r_ownerLdr <= 1'b1;
            r_dirWr    <= SC_MemArb_LdrWr_InHigh;
            r_memAddr  <= SC_MemArb_LdrAddr_InBUS;
            r_memData  <= SC_MemArb_LdrData_InBUS;
          end
        end
        S_ACCESS: begin
          r_cnt <= r_cnt + CNT_ONE;
          if (w_readyHit) begin
            if (!r_dirWr) begin
              if (r_ownerLdr) r_ldrData <= SC_MemArb_MemData_InBUS;
              else            r_cpuData <= SC_MemArb_MemData_InBUS;
            end
          end else if (w_timeout) begin
            // Aborted reads return zero so stale data is never mistaken for a result.
            r_error <= 1'b1;
            if (!r_dirWr) begin
              if (r_ownerLdr) r_ldrData <= '0;
              else            r_cpuData <= '0;
            end
          end
        end
        S_DONE:  r_lastLdr <= r_ownerLdr;
        default: r_lastLdr <= r_lastLdr;
      endcase
    end
  end

  assign SC_MemArb_MemRD_Out      = (r_state == S_ACCESS) & ~r_dirWr;
  assign SC_MemArb_MemWR_Out      = (r_state == S_ACCESS) &  r_dirWr;
  assign SC_MemArb_Done_Out       = (r_state == S_DONE)   & ~r_ownerLdr;
  assign SC_MemArb_LdrAck_Out     = (r_state == S_DONE)   &  r_ownerLdr;
  assign SC_MemArb_LdrGrant_Out   = ((r_state == S_ACCESS) | (r_state == S_DONE)) & r_ownerLdr;

  // A waiting CPU stays frozen through a loader DONE; it is only released in its own DONE.
  assign SC_MemArb_Stall_Out = ~SC_MemArb_RESET_InHigh & w_cpuReq &
                               ((r_state == S_IDLE) | (r_state == S_ACCESS) |
                                ((r_state == S_DONE) & r_ownerLdr));

  assign SC_MemArb_Data_OutBUS    = r_cpuData;
  assign SC_MemArb_LdrData_OutBUS = r_ldrData;
  assign SC_MemArb_MemAddr_OutBUS = r_memAddr;
  assign SC_MemArb_MemData_OutBUS = r_memData;
  assign SC_MemArb_Error_Out      = r_error;

endmodule

// File: tb/tb_sc_mem_access_arbiter.sv
// Randomized and directed bench for sc_mem_access_arbiter, checked every cycle against a
// transaction-level model of the arbiter.
module tb_sc_mem_access_arbiter;

  localparam int WS = 2;
  localparam int TO = 15;
  localparam int PH_IDLE   = 0;
  localparam int PH_ACCESS = 1;
  localparam int PH_DONE   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpuRd, cpuWr;
  logic [31:0] cpuAddr, cpuDataIn;
  logic        ldrReq, ldrWr;
  logic [31:0] ldrAddr, ldrDataIn;
  logic        memReady;
  logic [31:0] memDataIn;

  logic [31:0] dutCpuData, dutLdrData, memAddr, memData;
  logic        stall, done, ldrGrant, ldrAck, memRd, memWr, errorOut;

  int vectors = 0;
  int miscompares = 0;

  // Transaction-level model state.
  bit          modelValid = 1'b0;
  int          mPhase;
  int          mAge;
  bit          mOwnerLdr, mWr, mLastLdr, mErr;
  logic [31:0] mMemAddr, mMemData, mCpuData, mLdrData;

  always #5 clk = ~clk;

  sc_mem_access_arbiter #(
    .DATAWIDTH_ADDR(32), .DATAWIDTH_DATA(32), .WAIT_STATES(WS),
    .TIMEOUT_CYCLES(TO), .DATAWIDTH_TIMEOUT(4)
  ) dut (
    .SC_MemArb_CLOCK_50       (clk),
    .SC_MemArb_RESET_InHigh   (rst),
    .SC_MemArb_Read_InHigh    (cpuRd),
    .SC_MemArb_Write_InHigh   (cpuWr),
    .SC_MemArb_Addr_InBUS     (cpuAddr),
    .SC_MemArb_Data_InBUS     (cpuDataIn),
    .SC_MemArb_Data_OutBUS    (dutCpuData),
    .SC_MemArb_Stall_Out      (stall),
    .SC_MemArb_Done_Out       (done),
    .SC_MemArb_LdrReq_InHigh  (ldrReq),
    .SC_MemArb_LdrWr_InHigh   (ldrWr),
    .SC_MemArb_LdrAddr_InBUS  (ldrAddr),
    .SC_MemArb_LdrData_InBUS  (ldrDataIn),
    .SC_MemArb_LdrData_OutBUS (dutLdrData),
    .SC_MemArb_LdrGrant_Out   (ldrGrant),
    .SC_MemArb_LdrAck_Out     (ldrAck),
    .SC_MemArb_MemAddr_OutBUS (memAddr),
    .SC_MemArb_MemData_OutBUS (memData),
    .SC_MemArb_MemRD_Out      (memRd),
    .SC_MemArb_MemWR_Out      (memWr),
    .SC_MemArb_MemReady_InHigh(memReady),
    .SC_MemArb_MemData_InBUS  (memDataIn),
    .SC_MemArb_Error_Out      (errorOut)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: a transaction is granted from idle, spends numbered access cycles (1, 2, ...),
  // may finish once its cycle number exceeds the wait-state count with ready high, is
  // aborted on access cycle TO, then spends one done cycle.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        modelValid = 1'b1;
        mPhase = PH_IDLE; mAge = 0;
        mOwnerLdr = 1'b0; mWr = 1'b0; mLastLdr = 1'b1; mErr = 1'b0;
        mMemAddr = '0; mMemData = '0; mCpuData = '0; mLdrData = '0;
      end else if (modelValid) begin
        if (mPhase == PH_IDLE) begin
          if ((cpuRd || cpuWr) && (!ldrReq || mLastLdr)) begin
            mOwnerLdr = 1'b0; mWr = cpuWr && !cpuRd;
            mMemAddr = cpuAddr; mMemData = cpuDataIn;
            mPhase = PH_ACCESS; mAge = 0;
          end else if (ldrReq) begin
            mOwnerLdr = 1'b1; mWr = ldrWr;
            mMemAddr = ldrAddr; mMemData = ldrDataIn;
            mPhase = PH_ACCESS; mAge = 0;
          end
        end else if (mPhase == PH_ACCESS) begin
          mAge++;
          if (mAge > WS && memReady) begin
            if (!mWr) begin
              if (mOwnerLdr) mLdrData = memDataIn; else mCpuData = memDataIn;
            end
            mPhase = PH_DONE;
          end else if (mAge == TO) begin
            mErr = 1'b1;
            if (!mWr) begin
              if (mOwnerLdr) mLdrData = '0; else mCpuData = '0;
            end
            mPhase = PH_DONE;
          end
        end else begin
          mLastLdr = mOwnerLdr;
          mPhase = PH_IDLE;
        end
      end
    end
  end

  // Compare every output against the model mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (modelValid) begin
        automatic bit eAccess = (mPhase == PH_ACCESS);
        automatic bit eDone   = (mPhase == PH_DONE);
        automatic bit eStall  = !rst && (cpuRd || cpuWr) &&
                                (mPhase == PH_IDLE || eAccess || (eDone && mOwnerLdr));
        checkOutput("MemRD",    32'(memRd),    32'(eAccess && !mWr));
        checkOutput("MemWR",    32'(memWr),    32'(eAccess && mWr));
        checkOutput("Done",     32'(done),     32'(eDone && !mOwnerLdr));
        checkOutput("LdrAck",   32'(ldrAck),   32'(eDone && mOwnerLdr));
        checkOutput("LdrGrant", 32'(ldrGrant), 32'((eAccess || eDone) && mOwnerLdr));
        checkOutput("Stall",    32'(stall),    32'(eStall));
        checkOutput("Error",    32'(errorOut), 32'(mErr));
        checkOutput("MemAddr",  memAddr,       mMemAddr);
        checkOutput("MemData",  memData,       mMemData);
        checkOutput("DataOut",  dutCpuData,    mCpuData);
        checkOutput("LdrData",  dutLdrData,    mLdrData);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    cpuRd = 1'b0; cpuWr = 1'b0; cpuAddr = '0; cpuDataIn = '0;
    ldrReq = 1'b0; ldrWr = 1'b0; ldrAddr = '0; ldrDataIn = '0;
    memReady = 1'b0; memDataIn = '0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  // One CPU access; ready rises after readyAfter strobe cycles (0 = already high, -1 = never).
  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] data, input logic [31:0] word,
                               input int readyAfter, input int cycles,
                               output int rdCnt, output int wrCnt, output int stCnt,
                               output int dnCnt, output int doneGap);
    int lastStrobe = -99;
    int doneIdx = 0;
    bit seen = 1'b0;
    rdCnt = 0; wrCnt = 0; stCnt = 0; dnCnt = 0;
    cpuRd = rd; cpuWr = wr; cpuAddr = addr; cpuDataIn = data; memDataIn = word;
    memReady = (readyAfter == 0);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (memRd) begin rdCnt++; lastStrobe = i; end
      if (memWr) begin wrCnt++; lastStrobe = i; end
      if (stall) stCnt++;
      if (done) begin dnCnt++; doneIdx = i; seen = 1'b1; end
      tick();
      if (readyAfter > 0 && (rdCnt + wrCnt) == readyAfter && !seen) memReady = 1'b1;
      if (seen) begin cpuRd = 1'b0; cpuWr = 1'b0; memReady = 1'b0; end
    end
    doneGap = doneIdx - lastStrobe;
  endtask

  initial begin
    int rdCnt, wrCnt, stCnt, dnCnt, gap;
    int owners[8];
    int nOwn;
    int readyPct;
    int r;
    bit st, ack;

    doReset();
    checkOutput("reset Error", 32'(errorOut), 32'd0);
    checkOutput("reset DataOut", dutCpuData, 32'd0);

    // CPU read with ready tied high.
    applyStimulus(1'b1, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 10, rdCnt, wrCnt, stCnt, dnCnt, gap);
    checkOutput("read MemRD cycles", 32'(rdCnt), 32'd3);
    checkOutput("read Stall cycles", 32'(stCnt), 32'd4);
    checkOutput("read Done pulses", 32'(dnCnt), 32'd1);
    checkOutput("read DataOut", dutCpuData, 32'hDEADBEEF);
    checkOutput("read MemAddr", memAddr, 32'h100);

    // CPU write with ready delayed five strobe cycles.
    doReset();
    applyStimulus(1'b0, 1'b1, 32'h20, 32'h55AA, 32'h0, 5, 14, rdCnt, wrCnt, stCnt, dnCnt, gap);
    checkOutput("write MemWR cycles", 32'(wrCnt), 32'd6);
    checkOutput("write MemRD cycles", 32'(rdCnt), 32'd0);
    checkOutput("write Done pulses", 32'(dnCnt), 32'd1);
    checkOutput("write Done gap", 32'(gap), 32'd1);
    checkOutput("write MemData", memData, 32'h55AA);
    checkOutput("write Error", 32'(errorOut), 32'd0);

    // Both sides requesting continuously from reset.
    rst = 1'b1;
    cpuRd = 1'b1; cpuAddr = 32'h10; ldrReq = 1'b1; ldrWr = 1'b1;
    ldrAddr = 32'h80; ldrDataIn = 32'hA5; memReady = 1'b1; memDataIn = 32'h3C;
    repeat (2) tick();
    rst = 1'b0;
    nOwn = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (nOwn < 8 && done)   begin owners[nOwn] = 0; nOwn++; end
      if (nOwn < 8 && ldrAck) begin owners[nOwn] = 1; nOwn++; end
      tick();
    end
    cpuRd = 1'b0; ldrReq = 1'b0; memReady = 1'b0;
    checkOutput("rr completions", 32'(nOwn >= 4), 32'd1);
    checkOutput("rr grant0", 32'(owners[0]), 32'd0);
    checkOutput("rr grant1", 32'(owners[1]), 32'd1);
    checkOutput("rr grant2", 32'(owners[2]), 32'd0);
    checkOutput("rr grant3", 32'(owners[3]), 32'd1);

    // Timeout after a good read: data forced to zero, error sticky until reset.
    doReset();
    applyStimulus(1'b1, 1'b0, 32'h300, 32'h0, 32'h12345678, 0, 8, rdCnt, wrCnt, stCnt, dnCnt, gap);
    checkOutput("pre-timeout DataOut", dutCpuData, 32'h12345678);
    applyStimulus(1'b1, 1'b0, 32'h304, 32'h0, 32'hCAFEF00D, -1, 24, rdCnt, wrCnt, stCnt, dnCnt, gap);
    checkOutput("timeout MemRD cycles", 32'(rdCnt), 32'd15);
    checkOutput("timeout Done pulses", 32'(dnCnt), 32'd1);
    checkOutput("timeout Error", 32'(errorOut), 32'd1);
    checkOutput("timeout DataOut", dutCpuData, 32'd0);
    repeat (5) tick();
    checkOutput("sticky Error", 32'(errorOut), 32'd1);
    doReset();
    checkOutput("Error cleared", 32'(errorOut), 32'd0);

    // Reset on the second access cycle.
    cpuRd = 1'b1; cpuAddr = 32'h500; memReady = 1'b0;
    tick();
    @(negedge clk);
    checkOutput("abort first access MemRD", 32'(memRd), 32'd1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort Stall in reset", 32'(stall), 32'd0);
    tick();
    @(negedge clk);
    checkOutput("abort MemRD", 32'(memRd), 32'd0);
    checkOutput("abort Done", 32'(done), 32'd0);
    checkOutput("abort Error", 32'(errorOut), 32'd0);
    tick();
    rst = 1'b0; cpuRd = 1'b0;
    dnCnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) dnCnt++;
      tick();
    end
    checkOutput("abort no Done", 32'(dnCnt), 32'd0);

    // Read and write together behave as a read.
    applyStimulus(1'b1, 1'b1, 32'h40, 32'h77, 32'h9, 0, 10, rdCnt, wrCnt, stCnt, dnCnt, gap);
    checkOutput("rdwr MemRD cycles", 32'(rdCnt), 32'd3);
    checkOutput("rdwr MemWR cycles", 32'(wrCnt), 32'd0);
    checkOutput("rdwr MemAddr", memAddr, 32'h40);

    // Random traffic; requests only change when the requester is allowed to move on.
    doReset();
    readyPct = 70;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      st = stall;
      ack = ldrAck;
      tick();
      if (cyc % 64 == 0) readyPct = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(30, 100));
      rst = ($urandom_range(0, 399) == 0);
      if (!st) begin
        r = int'($urandom_range(0, 3));
        cpuRd = (r == 1 || r == 3);
        cpuWr = (r == 2 || r == 3);
        if (r != 0) begin cpuAddr = $urandom; cpuDataIn = $urandom; end
      end
      if (!ldrReq || ack) begin
        ldrReq = ($urandom_range(0, 2) == 0);
        ldrWr = 1'($urandom_range(0, 1));
        ldrAddr = $urandom;
        ldrDataIn = $urandom;
      end
      memReady = (int'($urandom_range(1, 100)) <= readyPct);
      memDataIn = $urandom;
    end
    rst = 1'b0; cpuRd = 1'b0; cpuWr = 1'b0; ldrReq = 1'b0;
    repeat (20) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
